// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract (denormals flushed, 255-exponent inputs unsupported).
// Build option: FP_ADDSUB_SEQ_ROUND_EN selects round-to-nearest-even; otherwise the result is truncated.
module fp_addsub_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [2:0]  OP_CODE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RESULT
);
  // state  | meaning
  // IDLE   | waiting for START, outputs hold last result
  // ALIGN  | smaller mantissa shifted right one bit per cycle
  // ADDSUB | signed-magnitude add/subtract of aligned mantissas
  // NORM   | carry shifted right or leading zeros shifted left
  // ROUND  | round-to-nearest-even (round build only)
  // FIN    | result packed, DONE pulsed on exit
  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, ROUND, FIN} state_t;

  state_t      state;
  logic        sign_x, sign_y, res_sign;
  logic        zero_f, ovf_f, unf_f, err_f;
  logic [7:0]  exp_r, shift_cnt;
  logic [26:0] man_x, man_y;
  logic [27:0] man;

  // mantissa layout: [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
  logic [7:0]  exp_a, exp_b;
  logic [26:0] ext_a, ext_b;
  logic        sign_b_eff, a_is_x;
  logic [27:0] sum;
  logic        sum_sign;

  always_comb begin
    exp_a      = A[30:23];
    exp_b      = B[30:23];
    ext_a      = (exp_a == 8'd0) ? 27'd0 : {1'b1, A[22:0], 3'b000};
    ext_b      = (exp_b == 8'd0) ? 27'd0 : {1'b1, B[22:0], 3'b000};
    sign_b_eff = B[31] ^ OP_CODE[0];
    a_is_x     = (exp_a >= exp_b);
  end

  always_comb begin
    sum      = 28'd0;
    sum_sign = sign_x;
    if (sign_x == sign_y) begin
      sum = {1'b0, man_x} + {1'b0, man_y};
    end else if (man_x >= man_y) begin
      sum = {1'b0, man_x} - {1'b0, man_y};
    end else begin
      sum      = {1'b0, man_y} - {1'b0, man_x};
      sum_sign = sign_y;
    end
  end

`ifdef FP_ADDSUB_SEQ_ROUND_EN
  logic        round_up;
  logic [24:0] rounded;
  always_comb begin
    round_up = man[2] & (man[1] | man[0] | man[3]);
    rounded  = {1'b0, man[26:3]} + {24'd0, round_up};
  end
  localparam state_t AFTER_NORM = ROUND;
`else
  localparam state_t AFTER_NORM = FIN;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      RESULT    <= 32'd0;
      sign_x    <= 1'b0;
      sign_y    <= 1'b0;
      res_sign  <= 1'b0;
      zero_f    <= 1'b0;
      ovf_f     <= 1'b0;
      unf_f     <= 1'b0;
      err_f     <= 1'b0;
      exp_r     <= 8'd0;
      shift_cnt <= 8'd0;
      man_x     <= 27'd0;
      man_y     <= 27'd0;
      man       <= 28'd0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          BUSY   <= 1'b1;
          zero_f <= 1'b0;
          ovf_f  <= 1'b0;
          unf_f  <= 1'b0;
          if (OP_CODE[2:1] != 2'b00) begin
            err_f <= 1'b1;
            state <= FIN;
          end else begin
            err_f <= 1'b0;
            if (a_is_x) begin
              sign_x    <= A[31];
              sign_y    <= sign_b_eff;
              man_x     <= ext_a;
              man_y     <= ext_b;
              exp_r     <= exp_a;
              shift_cnt <= exp_a - exp_b;
            end else begin
              sign_x    <= sign_b_eff;
              sign_y    <= A[31];
              man_x     <= ext_b;
              man_y     <= ext_a;
              exp_r     <= exp_b;
              shift_cnt <= exp_b - exp_a;
            end
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (shift_cnt == 8'd0) begin
            state <= ADDSUB;
          end else if (shift_cnt > 8'd26 || man_y == 27'd0) begin
            man_y     <= {26'd0, |man_y};
            shift_cnt <= 8'd0;
          end else begin
            man_y     <= {1'b0, man_y[26:2], man_y[1] | man_y[0]};
            shift_cnt <= shift_cnt - 8'd1;
          end
        end
        ADDSUB: begin
          man      <= sum;
          res_sign <= sum_sign;
          if (sum == 28'd0) begin
            zero_f <= 1'b1;
            state  <= FIN;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          if (man[27]) begin
            man <= {1'b0, man[27:2], man[1] | man[0]};
            if (exp_r == 8'd254) begin
              ovf_f <= 1'b1;
              state <= FIN;
            end else begin
              exp_r <= exp_r + 8'd1;
              state <= AFTER_NORM;
            end
          end else if (man[26]) begin
            state <= AFTER_NORM;
          end else if (exp_r == 8'd1) begin
            unf_f <= 1'b1;
            state <= FIN;
          end else begin
            man   <= {man[26:0], 1'b0};
            exp_r <= exp_r - 8'd1;
          end
        end
`ifdef FP_ADDSUB_SEQ_ROUND_EN
        ROUND: begin
          // a carry out of rounding leaves an all-zero fraction one binade up
          if (rounded[24]) begin
            man[26:3] <= rounded[24:1];
            if (exp_r == 8'd254) ovf_f <= 1'b1;
            else                 exp_r <= exp_r + 8'd1;
          end else begin
            man[26:3] <= rounded[23:0];
          end
          state <= FIN;
        end
`endif
        FIN: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          ERR   <= err_f;
          state <= IDLE;
          if (err_f || zero_f) RESULT <= 32'd0;
          else if (ovf_f)      RESULT <= {res_sign, 8'hFF, 23'd0};
          else if (unf_f)      RESULT <= {res_sign, 31'd0};
          else                 RESULT <= {res_sign, exp_r, man[25:3]};
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: vector table plus busy-ignore, illegal-op and mid-operation reset sequences.
module tb_fp_addsub_seq;
`ifdef FP_ADDSUB_SEQ_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  OP_CODE = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        BUSY, DONE, ERR;
  logic [31:0] RESULT;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  fp_addsub_seq dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP_CODE(OP_CODE), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (DONE) done_cnt++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!DONE && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, output int lat);
    @(posedge CLK); #1;
    A = a; B = b; OP_CODE = op; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int d0;
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 3'b000, 32'h40000000, 1'b0};
    vecs[1]  = '{32'h40400000, 32'hBFC00000, 3'b000, 32'h3FC00000, 1'b0};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 3'b001, 32'h00000000, 1'b0};
    vecs[3]  = '{32'h3F800001, 32'h33800000, 3'b000, RND ? 32'h3F800002 : 32'h3F800001, 1'b0};
    vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 32'h7F800000, 1'b0};
    vecs[5]  = '{32'h4B800000, 32'h40000000, 3'b000, 32'h4B800001, 1'b0};
    vecs[6]  = '{32'h3F800000, 32'h40000000, 3'b001, 32'hBF800000, 1'b0};
    vecs[7]  = '{32'h00000000, 32'h40A00000, 3'b000, 32'h40A00000, 1'b0};
    vecs[8]  = '{32'h00000001, 32'h3F800000, 3'b000, 32'h3F800000, 1'b0};
    vecs[9]  = '{32'hBF800000, 32'hBF800000, 3'b000, 32'hC0000000, 1'b0};
    vecs[10] = '{32'h00800000, 32'h00C00000, 3'b001, 32'h80000000, 1'b0};
    vecs[11] = '{32'h3F800000, 32'h33C00000, 3'b000, RND ? 32'h3F800001 : 32'h3F800000, 1'b0};
    vecs[12] = '{32'h3F7FFFFF, 32'h33000000, 3'b000, RND ? 32'h3F800000 : 32'h3F7FFFFF, 1'b0};
    vecs[13] = '{32'h3F800000, 32'h33800000, 3'b000, 32'h3F800000, 1'b0};
    vecs[14] = '{32'h40000000, 32'h3F800000, 3'b001, 32'h3F800000, 1'b0};
    vecs[15] = '{32'h3F800000, 32'h3F800000, 3'b010, 32'h00000000, 1'b1};
    vecs[16] = '{32'h40400000, 32'h3F800000, 3'b111, 32'h00000000, 1'b1};

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_result", RESULT, 32'd0);
    RST_N = 1'b1;

    for (int i = 0; i < 17; i++) begin
      d0 = done_cnt;
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
      chk($sformatf("v%0d_done", i), {31'd0, DONE}, 32'd1);
      chk($sformatf("v%0d_result", i), RESULT, vecs[i].res);
      chk($sformatf("v%0d_err", i), {31'd0, ERR}, {31'd0, vecs[i].err});
      if (vecs[i].err) chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, DONE}, 32'd0);
      chk($sformatf("v%0d_done_count", i), 32'(done_cnt - d0), 32'd1);
    end

    // START while busy must not disturb the running operation nor queue a second one
    d0 = done_cnt;
    @(posedge CLK); #1;
    A = 32'h4B800000; B = 32'h40000000; OP_CODE = 3'b000; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("busy_mid", {31'd0, BUSY}, 32'd1);
    A = 32'h3F800000; B = 32'h3F800000; OP_CODE = 3'b001; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(lat);
    chk("busy_ign_done", {31'd0, DONE}, 32'd1);
    chk("busy_ign_result", RESULT, 32'h4B800001);
    chk("busy_ign_err", {31'd0, ERR}, 32'd0);
    repeat (60) @(posedge CLK);
    #1;
    chk("busy_ign_count", 32'(done_cnt - d0), 32'd1);
    chk("busy_ign_idle", {31'd0, BUSY}, 32'd0);
    chk("busy_ign_hold", RESULT, 32'h4B800001);

    // reset during ALIGN aborts without DONE
    @(posedge CLK); #1;
    A = 32'h4B800000; B = 32'h40000000; OP_CODE = 3'b000; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    d0 = done_cnt;
    RST_N = 1'b0;
    #1;
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_result", RESULT, 32'd0);
    chk("abort_done", {31'd0, DONE}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_idle", {31'd0, BUSY}, 32'd0);
    run_op(32'h3F800000, 32'h3F800000, 3'b000, lat);
    chk("after_abort_done", {31'd0, DONE}, 32'd1);
    chk("after_abort_result", RESULT, 32'h40000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have no parameters; build variation only via the macro in Configuration.
REQ-002 SHALL have port CLK  input  1  single clock, rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port START  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port OP_CODE  input  3  000 = add, 001 = sub, others illegal.
REQ-006 SHALL have port A  input  32  IEEE-754 single operand A.
REQ-007 SHALL have port B  input  32  IEEE-754 single operand B.
REQ-008 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-009 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-010 SHALL have port ERR  output  1  illegal OP_CODE flag, valid with DONE.
REQ-011 SHALL have port RESULT  output  32  IEEE-754 single result, valid from DONE until next accepted START.

Function
REQ-012 SHALL implement FSM states IDLE, ALIGN, ADDSUB, NORM, FIN.
REQ-013 IDLE: START=1 -> capture A, B, OP_CODE, go ALIGN; illegal OP_CODE -> go FIN with ERR=1, RESULT=0.
REQ-014 Operands with exponent 0 SHALL be treated as signed zero (denormals flushed); exponent 255 inputs SHALL be out of scope (undefined result).
REQ-015 Mantissas SHALL be extended to 24 bits (hidden 1) plus guard, round and sticky bits.
REQ-016 Operand swap: larger-exponent operand becomes X; on equal exponents, A is X.
REQ-017 ALIGN: smaller mantissa shifted right 1 bit per cycle, shifted-out bits ORed into sticky, until exponents equal; exponent difference > 26 SHALL flush smaller to sticky-only in one cycle.
REQ-018 ADDSUB: one cycle; effective operation and sign per signed-magnitude rules (same-sign add or opposite-sign sub -> magnitude add, sign of A; else subtract smaller magnitude from larger, sign of larger, B sign inverted for sub); 25-bit sum.
REQ-019 NORM: carry out (bit 24) -> shift right 1, exponent +1, one cycle; else shift left 1 bit per cycle until bit 23 set.
REQ-020 Zero magnitude result SHALL give RESULT=32'h00000000 (+0), NORM skipped.
REQ-021 Exponent reaching 255 SHALL give signed infinity (mantissa 0); exponent dropping below 1 SHALL give signed zero.
REQ-022 FIN: RESULT registered, DONE=1 for exactly one cycle, return IDLE next cycle.
REQ-023 START while BUSY SHALL be ignored; no queuing.
REQ-024 START in the same cycle FIN returns to IDLE SHALL be ignored; acceptance only when state is IDLE.
REQ-025 Latency START->DONE SHALL be 3 + align cycles + norm cycles; worst case bounded at 3 + 27 + 24.

Reset
REQ-026 RST_N low SHALL immediately force IDLE, BUSY=0, DONE=0, ERR=0, RESULT=0, clear all internal registers.
REQ-027 Reset mid-operation SHALL abort the operation; no DONE SHALL be produced for it.

Configuration
REQ-028 Macro FP_ADDSUB_SEQ_ROUND_EN defined: round-to-nearest-even using guard/round/sticky after NORM, adding one ROUND cycle before FIN; rounding carry renormalized in that cycle.
REQ-029 Macro undefined: truncation (guard/round/sticky discarded), no ROUND cycle.

Verification
REQ-030 A=3F800000, B=3F800000, OP_CODE=000 -> RESULT=40000000, ERR=0, single DONE pulse.
REQ-031 A=40400000, B=BFC00000, OP=000 -> RESULT=3FC00000; A=3F800000, B=3F800000, OP=001 -> RESULT=00000000.
REQ-032 A=3F800001, B=33800000, OP=000 -> RESULT=3F800002 with ROUND_EN, 3F800001 without.
REQ-033 A=7F7FFFFF, B=7F7FFFFF, OP=000 -> RESULT=7F800000; A=4B800000, B=40000000 -> 4B800001.
REQ-034 OP_CODE=010 -> DONE two cycles after START, ERR=1, RESULT=0; START pulsed while BUSY -> ignored, original result unchanged.
REQ-035 RST_N low during ALIGN -> BUSY=0, RESULT=0 immediately, no DONE; next START runs normally.
